// File: rtl/sar_search_32_bit.sv
// sar_search_32_bit: MSB-first successive-approximation search that recovers
// an unsigned 32-bit target using only the lt/eq/gt flags of an external
// comparator whose B operand is Candidate_Out.
module sar_search_32_bit #(
  parameter int unsigned SETTLE_CYCLES = 0
) (
  input  logic        Clock_In,
  input  logic        Reset_In,
  input  logic        Start_In,
  input  logic        A_Less_Than_B_In,
  input  logic        A_Equal_To_B_In,
  input  logic        A_Greater_Than_B_In,
  output logic [31:0] Candidate_Out,
  output logic [31:0] Result_Out,
  output logic        Busy_Out,
  output logic        Done_Out,
  output logic        Error_Out,
  output logic [5:0]  Steps_Out
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Last settle count value; SETTLE is unreachable when SETTLE_CYCLES is 0.
  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  // State entered after every candidate update.
  localparam logic [1:0] STEP_STATE = (SETTLE_CYCLES > 0) ? SETTLE : SAMPLE;

  logic [1:0]  state;
  logic [31:0] work;
  logic [4:0]  bit_idx;
  logic [31:0] candidate;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic        error;
  logic [5:0]  steps;
  logic [3:0]  settle_cnt;

  logic [2:0]  flags;
  logic [31:0] bit_mask;
  logic [31:0] next_mask;
  logic [31:0] kept_work;

  // Per-step helpers: the bit under test, the next bit down, and the work
  // value after deciding the current bit (set only on GT).
  always_comb begin
    flags     = {A_Less_Than_B_In, A_Equal_To_B_In, A_Greater_Than_B_In};
    bit_mask  = 32'd1 << bit_idx;
    next_mask = bit_mask >> 1;
    kept_work = A_Greater_Than_B_In ? (work | bit_mask) : work;
  end

  // Search sequencer and all registered outputs.
  always_ff @(posedge Clock_In) begin
    if (!Reset_In) begin
      state      <= IDLE;
      work       <= '0;
      bit_idx    <= '0;
      candidate  <= '0;
      result     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      steps      <= '0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start_In) begin
            work       <= '0;
            bit_idx    <= 5'd31;
            candidate  <= 32'h8000_0000;
            steps      <= '0;
            error      <= 1'b0;
            busy       <= 1'b1;
            settle_cnt <= '0;
            state      <= STEP_STATE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        SAMPLE: begin
          steps <= steps + 6'd1;
          case (flags)
            3'b010: begin
              result <= candidate;
              state  <= DONE;
            end
            3'b100, 3'b001: begin
              if (bit_idx != 5'd0) begin
                work      <= kept_work;
                bit_idx   <= bit_idx - 5'd1;
                candidate <= kept_work | next_mask;
                state     <= STEP_STATE;
              end else if (A_Less_Than_B_In) begin
                result <= work;
                state  <= DONE;
              end else begin
                // GT at bit 0 means the target exceeds every reachable value.
                error  <= 1'b1;
                result <= candidate;
                state  <= DONE;
              end
            end
            default: begin
              error  <= 1'b1;
              result <= work;
              state  <= DONE;
            end
          endcase
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Candidate_Out = candidate;
  assign Result_Out    = result;
  assign Busy_Out      = busy;
  assign Done_Out      = done;
  assign Error_Out     = error;
  assign Steps_Out     = steps;

endmodule

// File: doc/sar_search_32_bit.md
SAR_SEARCH_32_BIT -- requirements
Module: sar_search_32_bit

Interface
REQ-001 Parameter SETTLE_CYCLES, default 0: idle cycles inserted between each Candidate_Out update and the cycle its compare flags are sampled (range 0-15).
REQ-002 Clock_In  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset_In  input  1  synchronous, active-low reset (0 at a rising Clock_In edge resets the block).
REQ-004 Start_In  input  1  begin a search; sampled only in IDLE.
REQ-005 A_Less_Than_B_In  input  1  external comparator flag: target < Candidate_Out.
REQ-006 A_Equal_To_B_In  input  1  external comparator flag: target == Candidate_Out.
REQ-007 A_Greater_Than_B_In  input  1  external comparator flag: target > Candidate_Out.
REQ-008 Candidate_Out  output  32  registered trial value, driven to the external comparator B operand.
REQ-009 Result_Out  output  32  recovered target value, valid when Done_Out=1.
REQ-010 Busy_Out  output  1  high from the cycle after Start_In acceptance until the DONE cycle.
REQ-011 Done_Out  output  1  single-cycle completion pulse.
REQ-012 Error_Out  output  1  flags not one-hot or inconsistent; held until next accepted start or reset.
REQ-013 Steps_Out  output  6  number of SAMPLE cycles taken in the current/last search (0-32).

Function
REQ-014 The block SHALL recover the unsigned 32-bit comparator target by MSB-first successive approximation using only the three flags.
REQ-015 States SHALL be IDLE, SETTLE, SAMPLE, DONE.
REQ-016 IDLE + Start_In=1: work=0, bit index i=31, Candidate_Out=0x8000_0000, Steps_Out=0, Error_Out=0, Busy_Out=1; next state SETTLE if SETTLE_CYCLES>0, else SAMPLE.
REQ-017 SETTLE SHALL count SETTLE_CYCLES cycles with Candidate_Out stable, then enter SAMPLE.
REQ-018 SAMPLE SHALL read flags in that cycle, increment Steps_Out, and act per REQ-019..REQ-023.
REQ-019 Flags not exactly one-hot: Error_Out=1, Result_Out=work, go DONE.
REQ-020 EQ: Result_Out=Candidate_Out, go DONE (early termination).
REQ-021 GT: work bit i kept set; LT: work bit i cleared.
REQ-022 i>0 after GT/LT: i decrements, Candidate_Out=work | (1<<(i-1)), re-enter SETTLE or SAMPLE per REQ-016.
REQ-023 i=0: LT -> Result_Out=work with bit 0 cleared, go DONE; GT -> Error_Out=1, Result_Out=Candidate_Out, go DONE.
REQ-024 DONE: Done_Out=1 for exactly one cycle, Busy_Out=0, next state IDLE; Result_Out, Candidate_Out, Steps_Out and Error_Out hold until the next accepted start.
REQ-025 Start_In SHALL be ignored in SETTLE, SAMPLE and DONE; no queuing.
REQ-026 Latency from Start_In edge to Done_Out: Steps_Out*(SETTLE_CYCLES+1)+1 cycles; maximum 32*(SETTLE_CYCLES+1)+1.
REQ-027 All arithmetic SHALL be unsigned 32-bit; bit-set operations SHALL never touch bits above index i.

Reset
REQ-028 Reset_In=0 at any edge, including mid-search, SHALL force IDLE next cycle with Candidate_Out=0, Result_Out=0, Busy_Out=0, Done_Out=0, Error_Out=0, Steps_Out=0, and the settle counter cleared.
REQ-029 Reset SHALL take priority over Start_In in the same cycle.

Verification
REQ-030 Bench models the comparator behaviourally against a target; SETTLE_CYCLES=0, target 0x8000_0000, Start pulse -> Done after 2 cycles, Result 0x8000_0000, Steps 1, Error 0.
REQ-031 Target 0x0000_0000 -> 32 LT samples, Result 0x0000_0000, Steps 32, Done 33 cycles after Start; target 0xFFFF_FFFF -> EQ on step 32, Result 0xFFFF_FFFF.
REQ-032 SETTLE_CYCLES=3, target 0x1234_5678 -> Result 0x1234_5678, Candidate stable 4 cycles per step, Done at Steps*4+1 cycles.
REQ-033 Force LT and GT simultaneously on step 5 -> Error 1, Done pulse, Steps 5, Result = work so far; GT forced at bit 0 -> Error 1.
REQ-034 Reset_In=0 at step 10 of a search -> all outputs zero next cycle, no Done pulse; Start_In during Busy -> ignored, search result unchanged.
REQ-035 Random targets (1000 runs, SETTLE_CYCLES 0 and 2) -> Result == target, Error 0, Done exactly once per Start.
